// File: rtl/data_mem_ctrl_if.sv
// Core-side request/response handshake for the data memory controller.
// The core drives the request fields; the controller returns ready, load data and store completion.
interface data_mem_ctrl_if #(
    parameter int AW = 8,
    parameter int W  = 8
);
    logic          req_valid;
    logic          req_we;
    logic [AW-1:0] req_addr;
    logic [W-1:0]  req_wdata;
    logic          req_ready;
    logic          rsp_valid;
    logic [W-1:0]  rsp_data;
    logic          wr_done;

    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_data, wr_done
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_data, wr_done
    );
endinterface

// File: rtl/data_mem_ctrl.sv
// Data memory initiator: one load/store at a time, owns the free-running 4-phase counter,
// holds stores until the memory's write phase and returns registered load data.
module data_mem_ctrl #(
    parameter  int N  = 256,
    parameter  int W  = 8,
    localparam int AW = $clog2(N)
) (
    input  logic          CLK,
    input  logic          init_n,
    data_mem_ctrl_if.slave bus,
    output logic [1:0]    Counter,
    output logic [AW-1:0] DataAddr,
    output logic          ReadMem,
    output logic          WriteMem,
    output logic [W-1:0]  DataIn,
    input  logic [W-1:0]  DataOut
);
    typedef enum logic [1:0] {S_IDLE, S_RD_ISSUE, S_RD_CAPTURE, S_WR_WAIT} state_t;

    state_t        r_state, w_next;
    logic [1:0]    r_phase;
    logic [AW-1:0] r_addr;
    logic [W-1:0]  r_wdata;
    logic [W-1:0]  r_rsp_data;
    logic          r_rsp_valid;
    logic          r_wr_done;
    logic          w_ready, w_accept, w_commit, w_rd, w_wr;

    always_ff @(posedge CLK or negedge init_n) begin
        if (!init_n) begin
            r_state <= S_IDLE;
            r_phase <= 2'd0;
        end else begin
            r_state <= w_next;
            r_phase <= r_phase + 2'd1;
        end
    end

    always_comb begin
        w_next   = r_state;
        w_ready  = 1'b0;
        w_rd     = 1'b0;
        w_wr     = 1'b0;
        w_commit = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_ready = init_n;
                if (bus.req_valid && init_n)
                    w_next = bus.req_we ? S_WR_WAIT : S_RD_ISSUE;
            end
            S_RD_ISSUE: begin
                w_rd   = 1'b1;
                w_next = S_RD_CAPTURE;
            end
            S_RD_CAPTURE: w_next = S_IDLE;
            S_WR_WAIT: begin
                w_wr = 1'b1;
                // Memory writes on the edge that leaves phase 2
                if (r_phase == 2'd2) begin
                    w_commit = 1'b1;
                    w_next   = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    assign w_accept = w_ready & bus.req_valid;

    always_ff @(posedge CLK or negedge init_n) begin
        if (!init_n) begin
            r_addr      <= '0;
            r_wdata     <= '0;
            r_rsp_data  <= '0;
            r_rsp_valid <= 1'b0;
            r_wr_done   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_addr  <= bus.req_addr;
                r_wdata <= bus.req_wdata;
            end
            if (r_state == S_RD_CAPTURE)
                r_rsp_data <= DataOut;
            r_rsp_valid <= (r_state == S_RD_CAPTURE);
            r_wr_done   <= w_commit;
        end
    end

    assign bus.req_ready = w_ready;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_data  = r_rsp_data;
    assign bus.wr_done   = r_wr_done;
    assign Counter       = r_phase;
    assign DataAddr      = r_addr;
    assign DataIn        = r_wdata;
    assign ReadMem       = w_rd;
    assign WriteMem      = w_wr;
endmodule

// File: doc/data_mem_ctrl.md
# data_mem_ctrl

Initiator-side controller for the processor's data memory. Accepts one load or store at a time from the core over a valid/ready handshake. Drives the memory's address, read, write, write-data and 2-bit phase (`Counter`) inputs, and returns registered load data to the core. It owns the free-running 4-phase counter; stores are held until the memory's write phase (`Counter == 2`).

## Interface
- `N`, 256, number of memory words; address width is `$clog2(N)`
- `W`, 8, data word width
- `CLK` input 1: single clock, all state on rising edge
- `init_n` input 1: reset, asynchronous, active-low
- `req_valid` input 1: core request present
- `req_we` input 1: 1 = store, 0 = load
- `req_addr` input `$clog2(N)`: word address
- `req_wdata` input W: store data
- `req_ready` output 1: controller accepts a request this cycle
- `rsp_valid` output 1: one-cycle pulse, `rsp_data` holds load result
- `rsp_data` output W: last load result, held until the next load completes
- `wr_done` output 1: one-cycle pulse, store committed
- `Counter` output 2: phase to memory
- `DataAddr` output `$clog2(N)`: address to memory
- `ReadMem` output 1: memory read strobe
- `WriteMem` output 1: memory write strobe
- `DataIn` output W: write data to memory
- `DataOut` input W: registered read data from memory, valid the cycle after a `ReadMem` edge

## Operation
- Phase counter: 2-bit, increments every cycle, wraps 3→0, free-running regardless of traffic; `Counter` = phase.
- States: IDLE, RD_ISSUE, RD_CAPTURE, WR_WAIT.
- IDLE:
  - `req_ready` = 1 (0 while `init_n` low).
  - A handshake (`req_valid & req_ready` at an edge) latches addr, wdata and we.
  - Next state is WR_WAIT if we = 1, else RD_ISSUE.
- RD_ISSUE: `ReadMem` = 1; next state RD_CAPTURE unconditionally.
- RD_CAPTURE:
  - `ReadMem` = 0.
  - At the edge: `rsp_data` <= `DataOut`, `rsp_valid` <= 1, next state IDLE.
- WR_WAIT:
  - `WriteMem` = 1.
  - At an edge where phase == 2, the memory commits. The same edge moves to IDLE and sets `wr_done` <= 1.
  - Otherwise stay in WR_WAIT.
- `DataAddr` and `DataIn` always equal the latched addr/wdata registers, stable for the whole transaction and held in IDLE.
- `ReadMem` and `WriteMem` decode from state only (Moore); never both 1.
- `rsp_valid` and `wr_done` are registered pulses, cleared the following cycle.
- One outstanding request only. `req_ready` = 0 in every non-IDLE state.

## Timing
- Reset (`init_n` low, asynchronous) forces:
  - state IDLE, phase 0;
  - `rsp_valid` = 0, `wr_done` = 0, `rsp_data` = 0;
  - latched addr/wdata = 0, so `DataAddr` = 0 and `DataIn` = 0;
  - `ReadMem` = `WriteMem` = 0, `Counter` = 0, `req_ready` = 0.
- After release, phase reads 0 in the first cycle and 1 after the next edge.
- Load latency:
  - Accept at edge E0, `ReadMem` high in cycle E0–E1, memory registers `DataOut` at E1.
  - `rsp_data` is captured at E2 and `rsp_valid` is high in cycle E2–E3.
  - That cycle is IDLE, so a new request can be accepted at E3.
- Store latency:
  - Accepted at the edge into phase p, commit at the first following edge that leaves phase 2.
  - p=2 → 1 cycle of `WriteMem`; p=3 → 4; p=0 → 3; p=1 → 2.
  - `wr_done` is high the cycle after the commit edge, which is IDLE.
- Back-to-back: requests may be accepted in the same cycle as the previous `rsp_valid`/`wr_done` pulse.
- `req_valid` with `req_ready` = 0 is ignored; the core holds the request.
- Reset mid-transaction: aborted immediately. No commit, no `rsp_valid`/`wr_done`, `rsp_data` cleared.
- Address N−1 and data all-ones are handled without wrap or truncation.

## Test plan
- Reset then idle 8 cycles:
  - `Counter` sequence 0,1,2,3,0,1,2,3.
  - `ReadMem` = `WriteMem` = 0, `req_ready` = 1 after release.
- Store 0xA5 to addr 0x10, accepted into phase 3:
  - `WriteMem` high 4 cycles, `DataAddr` = 0x10, `DataIn` = 0xA5.
  - Commit at the edge leaving phase 2, `wr_done` one cycle.
  - Repeat with acceptance into phase 2 → `WriteMem` 1 cycle.
- Store 0x3C to 0xFF, then load 0xFF:
  - `rsp_valid` 2 cycles after the load accept, `rsp_data` = 0x3C.
  - `rsp_data` held through later idle cycles.
- Back-to-back:
  - Load 0x00, then load 0x01 offered on the `rsp_valid` cycle and accepted there.
  - Responses return in order with correct data; `req_ready` low in RD_ISSUE/RD_CAPTURE.
- Assert `init_n` low during WR_WAIT:
  - Memory word unchanged on a later load.
  - No `wr_done`, all outputs at reset values, `Counter` restarts at 0.
- Random 500 loads/stores against a reference model:
  - All load data matches.
  - `ReadMem` & `WriteMem` never both 1.
  - `DataAddr` stable while either strobe is high.
